apu_stereo_mixer: RTL and testbench
===================================

// Module: apu_stereo_mixer
// PURPOSE
//  Time-multiplexed stereo mixer for the sound unit. Takes N_CH channel DAC levels (ch1..ch4 today) plus the
//  NR50/NR51/NR52 control fields, and produces signed SO1/SO2 PCM samples on request. The AC97 frame logic
//  requests one sample per frame. Generalises the single ch3_out path to any channel count, sample width and gain.
// PARAMETERS
//  N_CH        4   number of channels mixed; channel i occupies ch_level[i*SAMPLE_W +: SAMPLE_W]
//  SAMPLE_W    4   unsigned channel level width (0..2^SAMPLE_W-1)
//  OUT_W       16  signed output sample width per side
//  GAIN_SHIFT  6   left shift applied after volume scaling, before saturation
// PORTS
//  clk          in   1               sound clock (ac97_bitclk domain); all logic on rising edge
//  reset        in   1               synchronous, active-high
//  sample_req   in   1               1-cycle pulse: start a mix; inputs are snapshotted this cycle
//  ch_level     in   N_CH*SAMPLE_W   per-channel DAC level
//  ch_on        in   N_CH            per-channel on flag (ch*_on_flag)
//  so1_en       in   N_CH            NR51 SO1 routing mask
//  so2_en       in   N_CH            NR51 SO2 routing mask
//  so1_vol      in   3               NR50 SO1 output level
//  so2_vol      in   3               NR50 SO2 output level
//  master_en    in   1               NR52 sound_master_enable
//  so1_out      out  OUT_W           signed SO1 sample, held until next out_valid
//  so2_out      out  OUT_W           signed SO2 sample, held until next out_valid
//  out_valid    out  1               1-cycle pulse when so1_out/so2_out update
//  busy         out  1               high from the cycle after an accepted sample_req until out_valid
//  overrun      out  1               1-cycle pulse when sample_req arrives while busy (request dropped)
// BEHAVIOUR
//  - Reset: so1_out=so2_out=0, out_valid=0, busy=0, overrun=0, FSM=IDLE, accumulators=0. Reset mid-mix aborts with
//    no out_valid.
//  - FSM: IDLE --sample_req--> ACCUM (N_CH cycles, idx 0..N_CH-1, one channel per cycle, both sides in parallel)
//    --> SCALE (1 cycle) --> OUT (out_valid=1, outputs load) --> IDLE. The request at cycle 0 gives out_valid at
//    cycle N_CH+2.
//  - Snapshot: ch_level, ch_on, so*_en, so*_vol and master_en are registered on the accepting cycle. Later
//    input changes do not affect the current mix.
//  - DAC map: d_i = 2*level_i - (2^SAMPLE_W - 1), signed (level 0 -> -15, 15 -> +15 at SAMPLE_W=4).
//    A channel contributes d_i to side S only if ch_on[i] & soS_en[i]; otherwise it contributes 0 (not -15).
//  - Accumulator width: SAMPLE_W+1+clog2(N_CH) signed, so no internal overflow. SCALE: acc*(vol+1), +3 bits.
//  - Output: (scaled <<< GAIN_SHIFT), saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; no wrap-around.
//  - master_en=0 in snapshot: the mix still completes on schedule, and both outputs load 0 with out_valid.
//  - sample_req while busy (ACCUM/SCALE/OUT): ignored, overrun pulses the same cycle. A sample_req in the
//    OUT cycle is also an overrun. The FSM only accepts in IDLE.
//  - sample_req coincident with reset: reset wins, and no overrun is raised.
// STRUCTURE
//  - apu_pkg: FSM state enum (IDLE/ACCUM/SCALE/OUT), function dac_map(level), saturate function, DAC offset
//    constant.
//  - One sub-module apu_mix_side (accumulate+scale+saturate for one side), instantiated twice (SO1, SO2).
//    The top holds the FSM, the channel index counter, the snapshot registers and overrun.
// TESTING (N_CH=4, SAMPLE_W=4, OUT_W=16, GAIN_SHIFT=6 unless stated)
//  1. ch0=15 on, so1_en=0001, so2_en=0000, vols=7, master=1, req@0 -> out_valid@6, so1=7680, so2=0.
//  2. all levels 0, all on, both masks 1111, vol=7 -> so1=so2=-30720; all 15 -> +30720; so1_vol=0 -> so1=3840.
//  3. ch_on=0000 with masks 1111 -> both 0; master_en=0 with test-1 stimulus -> both 0, out_valid still @6.
//  4. GAIN_SHIFT=7, all levels 15, vol=7 -> so1=so2=32767 (saturated); all levels 0 -> -32768.
//  5. req@0, req@3 and @6 -> overrun pulses @3 and @6, one out_valid @6; req@7 is accepted, so valid@13.
//  6. reset asserted @3 of a mix -> no out_valid, outputs 0, busy 0 @4; change inputs @1 -> result uses @0 values.

Source files
------------

// File: rtl/apu_stereo_mixer_pkg.sv
// Shared types and helpers for the sound-unit stereo mixer.
// FSM states, DAC level mapping and output saturation.
package apu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SCALE,
    ST_OUT
  } state_e;

  // Width used for the scaled/shifted intermediate before clamping.
  localparam int WIDE_W = 48;

  // Midpoint offset of the DAC for the default 4-bit channel level.
  localparam int DAC_OFFSET = 15;

  // Unsigned channel level to signed DAC swing around zero.
  function automatic logic signed [15:0] dac_map(
    input logic [7:0] level,
    input int         sample_w
  );
    logic signed [15:0] l;
    logic signed [15:0] off;
    l   = signed'({8'd0, level});
    off = 16'((1 << sample_w) - 1);
    return (l <<< 1) - off;
  endfunction

  // Clamp to the signed range of an out_w-bit value.
  function automatic logic signed [WIDE_W-1:0] saturate(
    input logic signed [WIDE_W-1:0] v,
    input int                       out_w
  );
    logic signed [WIDE_W-1:0] one;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    one = 1;
    hi  = (one <<< (out_w - 1)) - one;
    lo  = -hi - one;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/apu_stereo_mixer_if.sv
// Request/sample bundle between frame logic and the mixer.
// master = requester, slave = mixer.
interface apu_stereo_mixer_if #(
  parameter int N_CH     = 4,
  parameter int SAMPLE_W = 4,
  parameter int OUT_W    = 16
);
  logic                       sample_req;
  logic [N_CH*SAMPLE_W-1:0]   ch_level;
  logic [N_CH-1:0]            ch_on;
  logic [N_CH-1:0]            so1_en;
  logic [N_CH-1:0]            so2_en;
  logic [2:0]                 so1_vol;
  logic [2:0]                 so2_vol;
  logic                       master_en;
  logic signed [OUT_W-1:0]    so1_out;
  logic signed [OUT_W-1:0]    so2_out;
  logic                       out_valid;
  logic                       busy;
  logic                       overrun;

  modport master (
    output sample_req, ch_level, ch_on,
    output so1_en, so2_en,
    output so1_vol, so2_vol, master_en,
    input  so1_out, so2_out,
    input  out_valid, busy, overrun
  );

  modport slave (
    input  sample_req, ch_level, ch_on,
    input  so1_en, so2_en,
    input  so1_vol, so2_vol, master_en,
    output so1_out, so2_out,
    output out_valid, busy, overrun
  );
endinterface

// File: rtl/apu_mix_side.sv
// One output side: accumulate routed channels,
// scale by volume and gain, then clamp.
module apu_mix_side
  import apu_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int SAMPLE_W   = 4,
  parameter int OUT_W      = 16,
  parameter int GAIN_SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    acc_en,
  input  logic                    load,
  input  logic                    master_en,
  input  logic                    en,
  input  logic [SAMPLE_W-1:0]     level,
  input  logic [2:0]              vol,
  output logic signed [OUT_W-1:0] out
);

  localparam int ACC_W = SAMPLE_W + 1 + $clog2(N_CH);

  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  contrib;
  logic signed [WIDE_W-1:0] acc_w;
  logic signed [WIDE_W-1:0] vol_w;
  logic signed [WIDE_W-1:0] scaled;
  logic signed [OUT_W-1:0]  out_q;
  logic signed [OUT_W-1:0]  out_d;

  // Next accumulator and output sample values.
  always_comb begin
    contrib = '0;
    if (en) begin
      contrib = ACC_W'(dac_map(8'(level), SAMPLE_W));
    end
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + contrib;
    end
    acc_w  = WIDE_W'(acc_q);
    vol_w  = WIDE_W'({1'b0, vol}) + WIDE_W'(1);
    scaled = (acc_w * vol_w) <<< GAIN_SHIFT;
    out_d  = out_q;
    if (load) begin
      out_d = '0;
      if (master_en) begin
        out_d = OUT_W'(saturate(scaled, OUT_W));
      end
    end
  end

  // Accumulator and held output sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/apu_stereo_mixer.sv
// Time-multiplexed stereo mixer: snapshots the
// controls, walks channels, emits SO1/SO2 samples.
module apu_stereo_mixer
  import apu_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int SAMPLE_W   = 4,
  parameter int OUT_W      = 16,
  parameter int GAIN_SHIFT = 6
) (
  input  logic             clk,
  input  logic             reset,
  apu_stereo_mixer_if.slave bus
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);
  localparam int LVL_W = N_CH * SAMPLE_W;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic [N_CH-1:0]     on_q, on_d;
  logic [N_CH-1:0]     e1_q, e1_d;
  logic [N_CH-1:0]     e2_q, e2_d;
  logic [2:0]          v1_q, v1_d;
  logic [2:0]          v2_q, v2_d;
  logic                mas_q, mas_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                accept;
  logic [SAMPLE_W-1:0] cur_lvl;
  logic signed [OUT_W-1:0] so1, so2;

  assign accept = (state_q == ST_IDLE) & bus.sample_req;

  // Sequencing and snapshot capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lvl_d   = lvl_q;
    on_d    = on_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    mas_d   = mas_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.sample_req) begin
          state_d = ST_ACCUM;
          idx_d   = '0;
          lvl_d   = bus.ch_level;
          on_d    = bus.ch_on;
          e1_d    = bus.so1_en;
          e2_d    = bus.so2_en;
          v1_d    = bus.so1_vol;
          v2_d    = bus.so2_vol;
          mas_d   = bus.master_en;
        end
      end
      ST_ACCUM: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_SCALE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_SCALE: state_d = ST_OUT;
      ST_OUT:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_OUT);
  end

  // Control and snapshot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lvl_q   <= '0;
      on_q    <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      mas_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lvl_q   <= lvl_d;
      on_q    <= on_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      mas_q   <= mas_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign cur_lvl = lvl_q[idx_q*SAMPLE_W +: SAMPLE_W];

  apu_mix_side #(
    .N_CH(N_CH), .SAMPLE_W(SAMPLE_W),
    .OUT_W(OUT_W), .GAIN_SHIFT(GAIN_SHIFT)
  ) u_so1 (
    .clk(clk), .reset(reset),
    .clr(accept),
    .acc_en(state_q == ST_ACCUM),
    .load(state_q == ST_SCALE),
    .master_en(mas_q),
    .en(on_q[idx_q] & e1_q[idx_q]),
    .level(cur_lvl), .vol(v1_q),
    .out(so1)
  );

  apu_mix_side #(
    .N_CH(N_CH), .SAMPLE_W(SAMPLE_W),
    .OUT_W(OUT_W), .GAIN_SHIFT(GAIN_SHIFT)
  ) u_so2 (
    .clk(clk), .reset(reset),
    .clr(accept),
    .acc_en(state_q == ST_ACCUM),
    .load(state_q == ST_SCALE),
    .master_en(mas_q),
    .en(on_q[idx_q] & e2_q[idx_q]),
    .level(cur_lvl), .vol(v2_q),
    .out(so2)
  );

  assign bus.so1_out   = so1;
  assign bus.so2_out   = so2;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = bus.sample_req & busy_q & ~reset;

endmodule

// File: tb/tb_apu_stereo_mixer.sv
// Scoreboard bench for apu_stereo_mixer at two gains.
// Directed cases followed by randomized traffic.
module tb_apu_stereo_mixer;

  localparam int NC  = 4;
  localparam int LAT = NC + 2;

  typedef struct {
    int so1;
    int so2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sreq;
  logic [15:0] slvl;
  logic [3:0]  son, s1e, s2e;
  logic [2:0]  s1v, s2v;
  logic        smas;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   acc_c  = -100;
  bit   run    = 0;
  bit   exp_busy, exp_valid, exp_ovr;
  exp_t q6[$];
  exp_t q7[$];
  exp_t h6 = '{0, 0};
  exp_t h7 = '{0, 0};

  always #5 clk = ~clk;

  apu_stereo_mixer_if #(.N_CH(4), .SAMPLE_W(4), .OUT_W(16)) bus6 ();
  apu_stereo_mixer_if #(.N_CH(4), .SAMPLE_W(4), .OUT_W(16)) bus7 ();

  assign bus6.sample_req = sreq;
  assign bus6.ch_level   = slvl;
  assign bus6.ch_on      = son;
  assign bus6.so1_en     = s1e;
  assign bus6.so2_en     = s2e;
  assign bus6.so1_vol    = s1v;
  assign bus6.so2_vol    = s2v;
  assign bus6.master_en  = smas;
  assign bus7.sample_req = sreq;
  assign bus7.ch_level   = slvl;
  assign bus7.ch_on      = son;
  assign bus7.so1_en     = s1e;
  assign bus7.so2_en     = s2e;
  assign bus7.so1_vol    = s1v;
  assign bus7.so2_vol    = s2v;
  assign bus7.master_en  = smas;

  apu_stereo_mixer #(
    .N_CH(4), .SAMPLE_W(4), .OUT_W(16), .GAIN_SHIFT(6)
  ) dut (
    .clk(clk), .reset(rst), .bus(bus6)
  );

  apu_stereo_mixer #(
    .N_CH(4), .SAMPLE_W(4), .OUT_W(16), .GAIN_SHIFT(7)
  ) dut7 (
    .clk(clk), .reset(rst), .bus(bus7)
  );

  // Reference: signed sum of routed DAC swings, volume, gain, clamp.
  function automatic int model(bit side2, int gain);
    int s;
    int v;
    bit r;
    s = 0;
    if (!smas) return 0;
    for (int i = 0; i < NC; i++) begin
      r = side2 ? s2e[i] : s1e[i];
      if (son[i] && r) s += 2 * int'(slvl[i*4 +: 4]) - 15;
    end
    v = side2 ? int'(s2v) : int'(s1v);
    s = s * (v + 1) * (1 << gain);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               n, cyc, act, exp);
    end
  endtask

  task automatic step(bit req, bit r);
    bit busy_now, valid_now;
    sreq = req;
    rst  = r;
    busy_now  = (cyc > acc_c) && (cyc <= acc_c + LAT);
    valid_now = (cyc == acc_c + LAT);
    exp_busy  = busy_now;
    exp_valid = valid_now;
    exp_ovr   = 1'b0;
    if (r) begin
      if (busy_now && !valid_now) begin
        q6.delete();
        q7.delete();
      end
      acc_c = -100;
    end else if (req) begin
      if (busy_now) begin
        exp_ovr = 1'b1;
      end else begin
        acc_c = cyc;
        q6.push_back('{model(0, 6), model(1, 6)});
        q7.push_back('{model(0, 7), model(1, 7)});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mix_once();
    step(1'b1, 1'b0);
    repeat (LAT + 1) step(1'b0, 1'b0);
  endtask

  task automatic set_t1();
    slvl = 16'h000F; son = 4'b0001;
    s1e = 4'b0001; s2e = 4'b0000;
    s1v = 3'd7; s2v = 3'd7; smas = 1'b1;
  endtask

  task automatic rnd_inputs();
    slvl = 16'($urandom);
    son  = 4'($urandom);
    s1e  = 4'($urandom);
    s2e  = 4'($urandom);
    s1v  = 3'($urandom);
    s2v  = 3'($urandom);
    smas = ($urandom_range(0, 7) != 0);
  endtask

  // Monitor for the gain-6 instance.
  always @(negedge clk) begin
    if (run) begin
      chk("busy6", int'(bus6.busy), int'(exp_busy));
      chk("valid6", int'(bus6.out_valid), int'(exp_valid));
      chk("ovr6", int'(bus6.overrun), int'(exp_ovr));
      if (bus6.out_valid) begin
        if (q6.size() == 0) begin
          chk("q6_empty_on_valid", 1, 0);
        end else begin
          h6 = q6.pop_front();
        end
      end
      chk("so1_g6", int'(bus6.so1_out), h6.so1);
      chk("so2_g6", int'(bus6.so2_out), h6.so2);
      if (rst) h6 = '{0, 0};
    end
  end

  // Monitor for the gain-7 instance.
  always @(negedge clk) begin
    if (run) begin
      chk("valid7", int'(bus7.out_valid), int'(exp_valid));
      chk("ovr7", int'(bus7.overrun), int'(exp_ovr));
      if (bus7.out_valid) begin
        if (q7.size() == 0) begin
          chk("q7_empty_on_valid", 1, 0);
        end else begin
          h7 = q7.pop_front();
        end
      end
      chk("so1_g7", int'(bus7.so1_out), h7.so1);
      chk("so2_g7", int'(bus7.so2_out), h7.so2);
      if (rst) h7 = '{0, 0};
    end
  end

  initial begin
    rst = 1'b1;
    sreq = 1'b0;
    set_t1();
    @(posedge clk);
    #1;
    run = 1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    set_t1();
    mix_once();
    slvl = 16'h0000; son = 4'hF;
    s1e = 4'hF; s2e = 4'hF;
    mix_once();
    slvl = 16'hFFFF;
    mix_once();
    s1v = 3'd0;
    mix_once();
    s1v = 3'd7; son = 4'h0;
    mix_once();
    set_t1(); smas = 1'b0;
    mix_once();

    set_t1();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (LAT + 1) step(1'b0, 1'b0);

    set_t1();
    step(1'b1, 1'b0);
    repeat (LAT + 1) begin
      rnd_inputs();
      step(1'b0, 1'b0);
    end

    set_t1();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (LAT + 1) step(1'b0, 1'b0);

    repeat (500) begin
      rnd_inputs();
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 59) == 0);
    end
    repeat (LAT + 2) step(1'b0, 1'b0);

    chk("q6_left", q6.size(), 0);
    chk("q7_left", q7.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
